// File: rtl/activation_feed_ctrl.sv
// activation_feed_ctrl
// Fetches a run of activation vectors from the activation SRAM and streams them
// into the skew Buffer, one vector per cycle. It then flushes until the last
// vector has cleared the skew stage and pulses done. It also produces per-row
// valid flags aligned with the Buffer outputs.

module activation_feed_ctrl #(
    parameter int SYSTOLIC_SIZE    = 8,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int CNT_WIDTH        = 10
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      test_mode_req,
    input  logic                                      abort,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [CNT_WIDTH-1:0]                      num_vectors,
    output logic                                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                     mem_rd_addr,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] mem_rd_data,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_in_flat,
    output logic                                      buf_test_mode,
    output logic [SYSTOLIC_SIZE-1:0]                  row_valid,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      aborted
);

    localparam int DATA_WIDTH = SYSTOLIC_SIZE * ACTIVATION_WIDTH;
    localparam int FLUSH_W    = $clog2(SYSTOLIC_SIZE + 2);

    // A normal flush lasts SYSTOLIC_SIZE+1 cycles and a bypass flush lasts 2.
    // The counter runs from 0, so these are the values held on the final flush cycle.
    localparam logic [FLUSH_W-1:0] FLUSH_LAST_NORMAL = FLUSH_W'(SYSTOLIC_SIZE);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST_TEST   = FLUSH_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic                   test_mode_q, test_mode_d;
    logic                   aborted_q, aborted_d;

    logic                   rd_valid_q, rd_valid_d;
    logic                   feed_valid_q, feed_valid_d;
    logic [DATA_WIDTH-1:0]  act_q, act_d;
    logic [SYSTOLIC_SIZE-1:0] skew_q, skew_d;

    logic [FLUSH_W-1:0]     flush_last;

    // Control registers: the state, the run parameters latched at start, and the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            flush_q     <= '0;
            test_mode_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            test_mode_q <= test_mode_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next state: accept a start in IDLE, count reads in STREAM, and time the drain in FLUSH
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        test_mode_d = test_mode_q;
        aborted_d   = aborted_q;
        flush_last  = test_mode_q ? FLUSH_LAST_TEST : FLUSH_LAST_NORMAL;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    num_d       = num_vectors;
                    test_mode_d = test_mode_req;
                    aborted_d   = 1'b0;
                    cnt_d       = '0;
                    flush_d     = '0;
                    state_d     = (num_vectors == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    flush_d   = '0;
                    state_d   = FLUSH;
                end else if (cnt_q == num_q - CNT_WIDTH'(1)) begin
                    flush_d = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (flush_q == flush_last) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: a read is issued on every STREAM cycle unless abort cuts the run short
    always_comb begin
        mem_rd_en   = (state_q == STREAM) && !abort;
        mem_rd_addr = mem_rd_en ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        aborted     = aborted_q;
    end

    // Feed pipeline: capture read data the cycle it returns, zeroing the filler cycles
    always_comb begin
        rd_valid_d   = mem_rd_en;
        feed_valid_d = rd_valid_q;
        act_d        = rd_valid_q ? mem_rd_data : '0;
        skew_d       = {skew_q[SYSTOLIC_SIZE-2:0], feed_valid_d & ~test_mode_q};
    end

    // Feed registers: bit i of the skew line holds feed_valid delayed by i cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q   <= 1'b0;
            feed_valid_q <= 1'b0;
            act_q        <= '0;
            skew_q       <= '0;
        end else begin
            rd_valid_q   <= rd_valid_d;
            feed_valid_q <= feed_valid_d;
            act_q        <= act_d;
            skew_q       <= skew_d;
        end
    end

    // Buffer-facing outputs: in bypass every row sees the vector at once; otherwise the rows follow the skew
    always_comb begin
        act_in_flat   = act_q;
        buf_test_mode = test_mode_q;
        row_valid     = test_mode_q ? {SYSTOLIC_SIZE{feed_valid_q}} : skew_q;
    end

endmodule

// File: tb/tb_activation_feed_ctrl.sv
// Testbench for activation_feed_ctrl.
// An SRAM model serves the reads. Each run's expected outputs are derived cycle by cycle
// from the run parameters, relative to the cycle in which start is asserted (cycle 0).

module tb_activation_feed_ctrl;

    localparam int S  = 8;
    localparam int AW = 8;
    localparam int DW = S * AW;
    localparam int ADW = 10;
    localparam int CW = 10;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           test_mode_req;
    logic           abort;
    logic [ADW-1:0] base_addr;
    logic [CW-1:0]  num_vectors;
    logic           mem_rd_en;
    logic [ADW-1:0] mem_rd_addr;
    logic [DW-1:0]  mem_rd_data;
    logic [DW-1:0]  act_in_flat;
    logic           buf_test_mode;
    logic [S-1:0]   row_valid;
    logic           busy;
    logic           done;
    logic           aborted;

    logic [DW-1:0]  mem [0:(1<<ADW)-1];

    int  checkCount;
    int  errorCount;
    bit  prevTm;
    bit  prevAborted;

    activation_feed_ctrl #(
        .SYSTOLIC_SIZE(S),
        .ACTIVATION_WIDTH(AW),
        .ADDR_WIDTH(ADW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .test_mode_req(test_mode_req),
        .abort(abort),
        .base_addr(base_addr),
        .num_vectors(num_vectors),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .act_in_flat(act_in_flat),
        .buf_test_mode(buf_test_mode),
        .row_valid(row_valid),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: data arrives the cycle after the strobe; other cycles carry junk
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= mem[mem_rd_addr];
        else
            mem_rd_data <= {$urandom, $urandom};
    end

    // Compare one observed value with its expected value and report any mismatch
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive the inputs for one cycle
    task automatic applyStimulus(input bit st, input bit tmr, input bit ab,
                                 input logic [ADW-1:0] b, input logic [CW-1:0] n);
        start         = st;
        test_mode_req = tmr;
        abort         = ab;
        base_addr     = b;
        num_vectors   = n;
    endtask

    function automatic bit feedAt(int t, int r);
        return (t >= 3) && (t <= r + 2);
    endfunction

    // One complete run. abortAt = 0 means no abort; poke adds ignored start/test_mode/abort activity
    task automatic runCase(input int n, input logic [ADW-1:0] base, input bit tm,
                           input int abortAt, input bit poke);
        int reads, flushStart, doneCycle;
        bit ab;
        logic [S-1:0] expRow;
        logic [ADW-1:0] expAddr;
        bit rdEn, stNow, tmNow, abNow;

        ab = 1'b0;
        flushStart = 0;
        if (n == 0) begin
            reads = 0;
            doneCycle = 1;
        end else begin
            if (abortAt >= 1 && abortAt <= n) begin
                reads = abortAt - 1;
                flushStart = abortAt + 1;
                ab = 1'b1;
            end else begin
                reads = n;
                flushStart = n + 1;
            end
            doneCycle = flushStart + (tm ? 2 : S + 1);
        end

        for (int c = 0; c <= doneCycle + 1; c++) begin
            @(posedge clk);
            #1;
            stNow = (c == 0) || (poke && c == 2 && doneCycle > 3);
            tmNow = (c == 0) ? tm : (poke ? 1'($urandom) : tm);
            abNow = (abortAt >= 1 && c == abortAt && n > 0) ||
                    (poke && n > 0 && c == flushStart + 1 && c < doneCycle);
            if (c == 0)
                applyStimulus(stNow, tmNow, abNow, base, CW'(n));
            else
                applyStimulus(stNow, tmNow, abNow, ADW'($urandom), CW'($urandom_range(0, 15)));

            @(negedge clk);
            rdEn    = (c >= 1) && (c <= reads);
            expAddr = rdEn ? ADW'(int'(base) + c - 1) : '0;
            for (int i = 0; i < S; i++)
                expRow[i] = tm ? feedAt(c, reads) : feedAt(c - i, reads);
            if (c == 0) expRow = '0;

            checkOutput("mem_rd_en", DW'(mem_rd_en), DW'(rdEn));
            checkOutput("mem_rd_addr", DW'(mem_rd_addr), DW'(expAddr));
            checkOutput("act_in_flat", act_in_flat,
                        feedAt(c, reads) ? mem[ADW'(int'(base) + c - 3)] : '0);
            checkOutput("row_valid", DW'(row_valid), DW'(expRow));
            checkOutput("busy", DW'(busy), DW'((c >= 1) && (c <= doneCycle)));
            checkOutput("done", DW'(done), DW'(c == doneCycle));
            checkOutput("aborted", DW'(aborted),
                        DW'((c == 0) ? prevAborted : (ab && n > 0 && c >= flushStart)));
            checkOutput("buf_test_mode", DW'(buf_test_mode), DW'((c == 0) ? prevTm : tm));
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        prevTm = tm;
        prevAborted = ab;
    endtask

    // Check every reset-controlled output is zero
    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_rd_en"}, DW'(mem_rd_en), '0);
        checkOutput({tag, " mem_rd_addr"}, DW'(mem_rd_addr), '0);
        checkOutput({tag, " act_in_flat"}, act_in_flat, '0);
        checkOutput({tag, " buf_test_mode"}, DW'(buf_test_mode), '0);
        checkOutput({tag, " row_valid"}, DW'(row_valid), '0);
        checkOutput({tag, " busy"}, DW'(busy), '0);
        checkOutput({tag, " done"}, DW'(done), '0);
        checkOutput({tag, " aborted"}, DW'(aborted), '0);
    endtask

    // Main sequence: directed runs from the block's documented scenarios, then random runs
    initial begin
        int n, ab, gap;
        logic [ADW-1:0] b;
        bit tm;

        checkCount = 0;
        errorCount = 0;
        prevTm = 1'b0;
        prevAborted = 1'b0;
        for (int a = 0; a < (1 << ADW); a++)
            mem[a] = {$urandom, $urandom};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("in reset");
        rst_n = 1'b1;
        #1;
        checkAllZero("after release");

        $display("[TB] directed runs");
        runCase(3, 10'h010, 1'b0, 0, 1'b0);
        runCase(3, 10'h020, 1'b1, 0, 1'b0);
        runCase(0, 10'h030, 1'b0, 0, 1'b0);
        runCase(4, 10'h3FE, 1'b0, 0, 1'b1);
        runCase(8, 10'h100, 1'b0, 3, 1'b0);
        runCase(2, 10'h200, 1'b0, 0, 1'b0);

        $display("[TB] reset mid-run");
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h055, CW'(8));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        checkOutput("pre-reset mem_rd_en", DW'(mem_rd_en), DW'(1));
        rst_n = 1'b0;
        #1;
        checkAllZero("mid-run reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkAllZero("mid-run release");
        prevTm = 1'b0;
        prevAborted = 1'b0;
        runCase(1, 10'h077, 1'b0, 0, 1'b0);

        $display("[TB] random runs");
        for (int r = 0; r < 14; r++) begin
            n  = $urandom_range(0, 12);
            b  = ($urandom_range(0, 2) == 0) ? ADW'(10'h3FC + $urandom_range(0, 3)) : ADW'($urandom);
            tm = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            runCase(n, b, tm, ab, 1'($urandom));
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
